// File: rtl/can_tx_scheduler_pkg.sv
// Purpose: shared sizing defaults and FSM encoding for the CAN transmit scheduler.
// Contents: default node count, data/ID widths, FIFO depth, retry limit, state type.
// Users: import can_tx_scheduler_pkg::* in the scheduler top and its FIFO.
package can_tx_scheduler_pkg;

    localparam int P_TOTAL_NODES = 4;
    localparam int P_DATA_SIZE   = 64;
    localparam int P_ID_SIZE     = 11;
    localparam int P_FIFO_DEPTH  = 8;
    localparam int P_MAX_RETRY   = 15;

    // Width of the retry counter output port.
    localparam int RETRY_W = 4;

    typedef enum logic [1:0] {
        SCH_IDLE  = 2'd0,
        SCH_LOAD  = 2'd1,
        SCH_WAIT  = 2'd2,
        SCH_RETRY = 2'd3
    } sched_state_t;

endpackage

// File: rtl/can_tx_scheduler_fifo.sv
// Purpose: synchronous packet FIFO buffering host packets ahead of the scheduler.
// Latency: a pushed word is visible at pop_dat from the cycle after the push; pop_dat is show-ahead.
// Backpressure: push_rdy is registered (count < DEPTH); a push into a full FIFO is refused even when popping.
// Ports: clock/reset (sync, active-low), push_vld/push_dat/push_rdy, pop/pop_dat, count.
module can_pkt_fifo
    import can_tx_scheduler_pkg::*;
#(
    parameter int DATA_W = P_DATA_SIZE,
    parameter int DEPTH  = P_FIFO_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_vld,
    input  logic [DATA_W-1:0]          push_dat,
    output logic                       push_rdy,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_dat,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_rdy_q, push_rdy_d;
    logic              do_push;
    logic              do_pop;

    assign do_push = push_vld && push_rdy_q;
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Registered ready tracks the next occupancy so it always equals count_q < DEPTH.
        push_rdy_d = (count_d < CW'(DEPTH));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            push_rdy_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            push_rdy_q <= push_rdy_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign pop_dat  = mem_q[rd_ptr_q];
    assign push_rdy = push_rdy_q;
    assign count    = count_q;

endmodule

// File: rtl/can_tx_scheduler.sv
// Purpose: grants one requesting CAN node at a time (round-robin), loads its packet/Tx_ID and the partner's Rx_ID.
// Latency: grant pulses two clocks after a request is driven in IDLE (IDLE -> LOAD -> grant registered).
// Backpressure: host sees registered pkt_ready from the FIFO; nodes wait in data_in_req until granted.
// Ports: clock/reset (sync, active-low), host pkt_* stream, id_load/id_cfg, per-node req/retransmit/completion,
//        per-node In_packet/Tx_ID/Rx_ID, grant, busy, retry_cnt, drop_err, fifo_count.
module can_tx_scheduler
    import can_tx_scheduler_pkg::*;
#(
    parameter int Total_Nodes = P_TOTAL_NODES,
    parameter int DATA_SIZE   = P_DATA_SIZE,
    parameter int ID_SIZE     = P_ID_SIZE,
    parameter int FIFO_DEPTH  = P_FIFO_DEPTH,
    parameter int MAX_RETRY   = P_MAX_RETRY
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             pkt_valid,
    input  logic [DATA_SIZE-1:0]             pkt_data,
    output logic                             pkt_ready,
    input  logic                             id_load,
    input  logic [Total_Nodes*ID_SIZE-1:0]   id_cfg,
    input  logic [Total_Nodes-1:0]           data_in_req,
    input  logic [Total_Nodes-1:0]           Retransmit,
    input  logic [Total_Nodes-1:0]           data_out_req,
    output logic [Total_Nodes*DATA_SIZE-1:0] In_packet,
    output logic [Total_Nodes*ID_SIZE-1:0]   Tx_ID,
    output logic [Total_Nodes*ID_SIZE-1:0]   Rx_ID,
    output logic [Total_Nodes-1:0]           grant,
    output logic                             busy,
    output logic [RETRY_W-1:0]               retry_cnt,
    output logic                             drop_err,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count
);

    localparam int NODE_W = $clog2(Total_Nodes);

    sched_state_t           state_q, state_d;
    logic [NODE_W-1:0]      g_q, g_d;
    logic [NODE_W-1:0]      rr_q, rr_d;
    logic [Total_Nodes-1:0] grant_q, grant_d;
    logic                   busy_q, busy_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic                   drop_q, drop_d;
    logic [ID_SIZE-1:0]     id_q     [Total_Nodes];
    logic [ID_SIZE-1:0]     id_d     [Total_Nodes];
    logic [DATA_SIZE-1:0]   in_pkt_q [Total_Nodes];
    logic [DATA_SIZE-1:0]   in_pkt_d [Total_Nodes];
    logic [ID_SIZE-1:0]     tx_q     [Total_Nodes];
    logic [ID_SIZE-1:0]     tx_d     [Total_Nodes];
    logic [ID_SIZE-1:0]     rx_q     [Total_Nodes];
    logic [ID_SIZE-1:0]     rx_d     [Total_Nodes];

    logic                   fifo_pop;
    logic [DATA_SIZE-1:0]   fifo_dat;
    logic [NODE_W-1:0]      g_partner;
    logic [NODE_W-1:0]      g_next;

    can_pkt_fifo #(
        .DATA_W (DATA_SIZE),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (pkt_valid),
        .push_dat (pkt_data),
        .push_rdy (pkt_ready),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .count    (fifo_count)
    );

    // First requesting node at or after ptr, wrapping past the last node.
    function automatic logic [NODE_W-1:0] rr_select(input logic [Total_Nodes-1:0] req,
                                                    input logic [NODE_W-1:0]      ptr);
        logic [NODE_W-1:0] sel;
        logic              found;
        int                idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < Total_Nodes; k++) begin
            idx = (int'(ptr) + k) % Total_Nodes;
            if (!found && req[NODE_W'(idx)]) begin
                sel   = NODE_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Nodes are paired (0,1), (2,3), ...; the partner receives the granted node's frames.
    assign g_partner = g_q ^ NODE_W'(1);
    assign g_next    = (g_q == NODE_W'(Total_Nodes - 1)) ? '0 : g_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        rr_d     = rr_q;
        grant_d  = '0;
        busy_d   = busy_q;
        retry_d  = retry_q;
        drop_d   = 1'b0;
        id_d     = id_q;
        in_pkt_d = in_pkt_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        fifo_pop = 1'b0;

        case (state_q)
            SCH_IDLE: begin
                if (id_load) begin
                    for (int i = 0; i < Total_Nodes; i++) begin
                        id_d[i] = id_cfg[i*ID_SIZE +: ID_SIZE];
                    end
                end
                if ((|data_in_req) && (fifo_count != '0)) begin
                    g_d     = rr_select(data_in_req, rr_q);
                    state_d = SCH_LOAD;
                end
            end
            SCH_LOAD: begin
                fifo_pop          = 1'b1;
                in_pkt_d[g_q]     = fifo_dat;
                tx_d[g_q]         = id_q[g_q];
                rx_d[g_partner]   = id_q[g_q];
                grant_d[g_q]      = 1'b1;
                retry_d           = '0;
                busy_d            = 1'b1;
                state_d           = SCH_WAIT;
            end
            SCH_WAIT: begin
                // Completion has priority over a coincident bus error.
                if (|data_out_req) begin
                    rr_d    = g_next;
                    busy_d  = 1'b0;
                    state_d = SCH_IDLE;
                end else if (Retransmit[g_q]) begin
                    state_d = SCH_RETRY;
                end
            end
            SCH_RETRY: begin
                if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
                    drop_d  = 1'b1;
                    rr_d    = g_next;
                    busy_d  = 1'b0;
                    state_d = SCH_IDLE;
                end else begin
                    if (retry_q != '1) begin
                        retry_d = retry_q + 1'b1;
                    end
                    // ID 0 wins arbitration on the bus, so a resend goes out first.
                    tx_d[g_q]       = '0;
                    rx_d[g_partner] = '0;
                    grant_d[g_q]    = 1'b1;
                    state_d         = SCH_WAIT;
                end
            end
            default: begin
                state_d = SCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= SCH_IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            retry_q <= '0;
            drop_q  <= 1'b0;
            for (int i = 0; i < Total_Nodes; i++) begin
                id_q[i]     <= '0;
                in_pkt_q[i] <= '0;
                tx_q[i]     <= '0;
                rx_q[i]     <= '0;
            end
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            retry_q  <= retry_d;
            drop_q   <= drop_d;
            id_q     <= id_d;
            in_pkt_q <= in_pkt_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    for (genvar i = 0; i < Total_Nodes; i++) begin : g_flat
        assign In_packet[i*DATA_SIZE +: DATA_SIZE] = in_pkt_q[i];
        assign Tx_ID[i*ID_SIZE +: ID_SIZE]         = tx_q[i];
        assign Rx_ID[i*ID_SIZE +: ID_SIZE]         = rx_q[i];
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign retry_cnt = retry_q;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
module tb_can_tx_scheduler;

    localparam int N     = 4;
    localparam int DW    = 64;
    localparam int IW    = 11;
    localparam int DEPTH = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              pkt_valid;
    logic [DW-1:0]     pkt_data;
    logic              pkt_ready;
    logic              id_load;
    logic [N*IW-1:0]   id_cfg;
    logic [N-1:0]      data_in_req;
    logic [N-1:0]      Retransmit;
    logic [N-1:0]      data_out_req;
    logic [N*DW-1:0]   In_packet;
    logic [N*IW-1:0]   Tx_ID;
    logic [N*IW-1:0]   Rx_ID;
    logic [N-1:0]      grant;
    logic              busy;
    logic [3:0]        retry_cnt;
    logic              drop_err;
    logic [3:0]        fifo_count;

    can_tx_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .pkt_valid    (pkt_valid),
        .pkt_data     (pkt_data),
        .pkt_ready    (pkt_ready),
        .id_load      (id_load),
        .id_cfg       (id_cfg),
        .data_in_req  (data_in_req),
        .Retransmit   (Retransmit),
        .data_out_req (data_out_req),
        .In_packet    (In_packet),
        .Tx_ID        (Tx_ID),
        .Rx_ID        (Rx_ID),
        .grant        (grant),
        .busy         (busy),
        .retry_cnt    (retry_cnt),
        .drop_err     (drop_err),
        .fifo_count   (fifo_count)
    );

    always #5 clock = ~clock;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] sb [$];
    int            model_cnt = 0;
    logic [IW-1:0] id_tab [N];
    logic [DW-1:0] last_pkt;

    typedef struct {
        logic [N-1:0] req;
        int           node;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pkt_of(input int i);
        return In_packet[i*DW +: DW];
    endfunction
    function automatic logic [IW-1:0] tx_of(input int i);
        return Tx_ID[i*IW +: IW];
    endfunction
    function automatic logic [IW-1:0] rx_of(input int i);
        return Rx_ID[i*IW +: IW];
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Bench decides acceptance from its own occupancy model.
    task automatic push_pkt(input logic [DW-1:0] d);
        pkt_valid = 1'b1;
        pkt_data  = d;
        step();
        pkt_valid = 1'b0;
        if (model_cnt < DEPTH) begin
            sb.push_back(d);
            model_cnt++;
        end
        chk("push_fifo_count", fifo_count, model_cnt);
        chk("push_pkt_ready", pkt_ready, model_cnt < DEPTH);
    endtask

    task automatic start_frame(input logic [N-1:0] req, input int node, input logic [IW-1:0] exp_id);
        int lat;
        lat         = 0;
        data_in_req = req;
        while (grant == '0 && lat < 10) begin
            step();
            lat++;
        end
        data_in_req = '0;
        last_pkt    = (sb.size() != 0) ? sb.pop_front() : '0;
        model_cnt--;
        chk("grant_latency", lat, 2);
        chk("grant_onehot", grant, 1 << node);
        chk("in_packet", pkt_of(node), last_pkt);
        chk("tx_id", tx_of(node), exp_id);
        chk("rx_id_partner", rx_of(node ^ 1), exp_id);
        chk("load_fifo_count", fifo_count, model_cnt);
        chk("load_busy", busy, 1);
        chk("load_retry_cnt", retry_cnt, 0);
        step();
        chk("grant_one_cycle", grant, 0);
    endtask

    task automatic end_frame(input int node);
        data_out_req = 4'b0001 << (node ^ 1);
        step();
        data_out_req = '0;
        chk("done_busy", busy, 0);
        chk("done_grant", grant, 0);
    endtask

    initial begin
        int grants;
        int drops;
        int cyc;

        reset        = 1'b0;
        pkt_valid    = 1'b0;
        pkt_data     = '0;
        id_load      = 1'b0;
        id_cfg       = '0;
        data_in_req  = '0;
        Retransmit   = '0;
        data_out_req = '0;

        // Reset state.
        step();
        step();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_ready", pkt_ready, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_tx_id", Tx_ID, 0);
        chk("rst_rx_id", Rx_ID, 0);
        reset = 1'b1;
        step();
        chk("rel_pkt_ready", pkt_ready, 1);

        // ID table and first frame to node 0.
        id_tab[0] = 11'h100; id_tab[1] = 11'h101; id_tab[2] = 11'h102; id_tab[3] = 11'h103;
        id_cfg  = {id_tab[3], id_tab[2], id_tab[1], id_tab[0]};
        id_load = 1'b1;
        step();
        id_load = 1'b0;
        push_pkt(64'hA5A5_A5A5_A5A5_A5A5);
        push_pkt(64'h5A5A_5A5A_5A5A_5A5A);
        start_frame(4'b0001, 0, id_tab[0]);
        end_frame(0);

        // Round-robin table; rr pointer starts at 1 after the first frame.
        tbl[0] = '{4'b1111, 1};
        tbl[1] = '{4'b1111, 2};
        tbl[2] = '{4'b1111, 3};
        tbl[3] = '{4'b1111, 0};
        tbl[4] = '{4'b0001, 0};
        tbl[5] = '{4'b1000, 3};
        tbl[6] = '{4'b0110, 1};
        tbl[7] = '{4'b0011, 0};
        tbl[8] = '{4'b0100, 2};
        tbl[9] = '{4'b1010, 3};
        for (int i = 0; i < 10; i++) begin
            push_pkt(64'h1000_0000_0000_0000 + 64'(i * 17));
            start_frame(tbl[i].req, tbl[i].node, id_tab[tbl[i].node]);
            end_frame(tbl[i].node);
        end

        // Retransmit on node 2 (rr pointer now 0).
        push_pkt(64'hDEAD_BEEF_0000_0002);
        start_frame(4'b0100, 2, id_tab[2]);
        Retransmit = 4'b0001;
        step();
        Retransmit = '0;
        step();
        chk("other_retx_grant", grant, 0);
        chk("other_retx_retry", retry_cnt, 0);
        chk("other_retx_busy", busy, 1);
        Retransmit = 4'b0100;
        step();
        Retransmit = '0;
        step();
        chk("retx_grant", grant, 4'b0100);
        chk("retx_tx_id", tx_of(2), 0);
        chk("retx_rx_id", rx_of(3), 0);
        chk("retx_retry_cnt", retry_cnt, 1);
        chk("retx_fifo_count", fifo_count, model_cnt);
        chk("retx_in_packet", pkt_of(2), last_pkt);

        // Keep the error asserted until the frame is abandoned.
        grants = 0;
        drops  = 0;
        cyc    = 0;
        Retransmit = 4'b0100;
        while (drops == 0 && cyc < 80) begin
            step();
            cyc++;
            if (grant[2]) grants++;
            if (drop_err) begin
                drops++;
                chk("drop_retry_cnt", retry_cnt, 14);
            end
        end
        Retransmit = '0;
        chk("drop_regrants", grants, 13);
        chk("drop_pulses", drops, 1);
        chk("drop_busy", busy, 0);
        step();
        chk("drop_one_cycle", drop_err, 0);
        push_pkt(64'hCAFE_0000_0000_0003);
        start_frame(4'b1111, 3, id_tab[3]);
        end_frame(3);

        // Completion and Retransmit in the same cycle: completion wins.
        push_pkt(64'hCAFE_0000_0000_0001);
        start_frame(4'b0010, 1, id_tab[1]);
        data_out_req = 4'b0001;
        Retransmit   = 4'b0010;
        step();
        data_out_req = '0;
        Retransmit   = '0;
        chk("both_busy", busy, 0);
        step();
        chk("both_grant", grant, 0);
        chk("both_retry", retry_cnt, 0);

        // id_load outside IDLE is ignored.
        push_pkt(64'h0123_4567_89AB_CDEF);
        start_frame(4'b0001, 0, id_tab[0]);
        id_cfg  = '1;
        id_load = 1'b1;
        step();
        id_load = 1'b0;
        end_frame(0);
        push_pkt(64'hFEDC_BA98_7654_3210);
        start_frame(4'b0001, 0, id_tab[0]);
        end_frame(0);

        // Fill past capacity with no requests.
        for (int i = 0; i < 9; i++) begin
            push_pkt(64'h2000_0000_0000_0000 + 64'(i));
        end
        chk("full_count", fifo_count, 8);
        chk("full_ready", pkt_ready, 0);

        // Host holds a packet while full; it lands once LOAD frees a slot.
        pkt_valid   = 1'b1;
        pkt_data    = 64'h3000_0000_0000_0009;
        data_in_req = 4'b0001;
        step();
        chk("full_refused", fifo_count, 8);
        step();
        data_in_req = '0;
        last_pkt    = sb.pop_front();
        model_cnt   = 7;
        chk("full_pop_grant", grant, 4'b0001);
        chk("full_pop_count", fifo_count, 7);
        chk("full_pop_ready", pkt_ready, 1);
        chk("full_pop_packet", pkt_of(0), last_pkt);
        step();
        pkt_valid = 1'b0;
        sb.push_back(64'h3000_0000_0000_0009);
        model_cnt = 8;
        chk("refill_count", fifo_count, 8);
        chk("refill_ready", pkt_ready, 0);
        end_frame(0);
        start_frame(4'b0001, 0, id_tab[0]);
        end_frame(0);

        // Push lands in the same cycle as the LOAD pop.
        data_in_req = 4'b0001;
        step();
        pkt_valid   = 1'b1;
        pkt_data    = 64'h3000_0000_0000_000A;
        step();
        pkt_valid   = 1'b0;
        data_in_req = '0;
        last_pkt    = sb.pop_front();
        sb.push_back(64'h3000_0000_0000_000A);
        chk("pushpop_grant", grant, 4'b0001);
        chk("pushpop_count", fifo_count, 7);
        chk("pushpop_packet", pkt_of(0), last_pkt);
        end_frame(0);

        // Reset while a frame is in flight.
        start_frame(4'b0100, 2, id_tab[2]);
        reset = 1'b0;
        step();
        chk("midrst_busy", busy, 0);
        chk("midrst_grant", grant, 0);
        chk("midrst_retry", retry_cnt, 0);
        chk("midrst_drop", drop_err, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_ready", pkt_ready, 0);
        chk("midrst_tx", Tx_ID, 0);
        chk("midrst_rx", Rx_ID, 0);
        for (int i = 0; i < N; i++) begin
            chk("midrst_in_packet", pkt_of(i), 0);
        end
        reset = 1'b1;
        step();
        chk("postrst_ready", pkt_ready, 1);
        chk("postrst_count", fifo_count, 0);
        sb.delete();
        model_cnt = 0;

        // ID table and rr pointer are back to zero.
        push_pkt(64'h4444_4444_4444_4444);
        start_frame(4'b1111, 0, 11'h000);
        end_frame(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
